// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between instruction fetch and load/store.
// One transaction in flight; D has priority, bounded by a fetch-starvation guard.
module mem_port_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MAX_D_BURST = 4,
    parameter int TIMEOUT     = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_gnt,
    output logic                i_rvalid,
    output logic [DATA_W-1:0]   i_rdata,
    output logic                i_err,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_wstrb,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_err,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic                mem_gnt,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int SW = $clog2(MAX_D_BURST + 1);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP
    } state_t;

    state_t              state;
    state_t              state_next;
    logic                owner_d;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W/8-1:0] wstrb_q;
    logic [SW-1:0]       streak;
    logic [TW-1:0]       timer;
    logic                d_win;
    logic                wd_hit;
    logic                done;
    logic                tmo;

    assign d_win  = d_req && !(i_req && streak == SW'(MAX_D_BURST));
    assign wd_hit = (TIMEOUT != 0) && (timer == TW'(TIMEOUT - 1));

    assign mem_req   = (state == REQ);
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_wstrb = wstrb_q;

    always_comb begin
        state_next = state;
        i_gnt      = 1'b0;
        d_gnt      = 1'b0;
        done       = 1'b0;
        tmo        = 1'b0;
        unique case (state)
            IDLE: begin
                if (!rst) begin
                    if (d_win) begin
                        d_gnt = 1'b1;
                    end else if (i_req) begin
                        i_gnt = 1'b1;
                    end
                end
                if (i_gnt || d_gnt) state_next = REQ;
            end
            REQ: begin
                if (mem_gnt && mem_rvalid) begin
                    done = 1'b1;
                end else if (wd_hit) begin
                    tmo = 1'b1;
                end else if (mem_gnt) begin
                    state_next = RESP;
                end
                if (done || tmo) state_next = IDLE;
            end
            RESP: begin
                if (mem_rvalid) begin
                    done = 1'b1;
                end else if (wd_hit) begin
                    tmo = 1'b1;
                end
                if (done || tmo) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            owner_d  <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            streak   <= '0;
            timer    <= '0;
            i_rvalid <= 1'b0;
            i_rdata  <= '0;
            i_err    <= 1'b0;
            d_rvalid <= 1'b0;
            d_rdata  <= '0;
            d_err    <= 1'b0;
        end else begin
            state    <= state_next;
            i_rvalid <= 1'b0;
            i_err    <= 1'b0;
            d_rvalid <= 1'b0;
            d_err    <= 1'b0;
            if (i_gnt || d_gnt) begin
                owner_d <= d_gnt;
                we_q    <= d_gnt && d_we;
                addr_q  <= d_gnt ? d_addr : i_addr;
                wdata_q <= d_gnt ? d_wdata : '0;
                wstrb_q <= d_gnt ? d_wstrb : '1;
                timer   <= '0;
            end else if (state != IDLE) begin
                timer <= timer + 1'b1;
            end
            // Streak only grows while fetch is actually waiting behind D
            if (d_gnt) begin
                if (!i_req) begin
                    streak <= '0;
                end else if (streak != SW'(MAX_D_BURST)) begin
                    streak <= streak + 1'b1;
                end
            end else if (i_gnt) begin
                streak <= '0;
            end
            if (done || tmo) begin
                if (owner_d) begin
                    d_rvalid <= 1'b1;
                    d_err    <= tmo;
                    d_rdata  <= tmo ? '0 : mem_rdata;
                end else begin
                    i_rvalid <= 1'b1;
                    i_err    <= tmo;
                    i_rdata  <= tmo ? '0 : mem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-level model.
// Memory side is a random responder that sometimes goes silent.
module tb_mem_port_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int MAXB = 4;
    localparam int TO   = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_gnt;
    logic          i_rvalid;
    logic [DW-1:0] i_rdata;
    logic          i_err;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [3:0]    d_wstrb;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          d_err;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [3:0]    mem_wstrb;
    logic          mem_gnt;
    logic          mem_rvalid;
    logic [DW-1:0] mem_rdata;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .MAX_D_BURST(MAXB), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt),
        .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_err(i_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_wstrb(d_wstrb), .d_gnt(d_gnt),
        .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Transaction-level model state
    int            streak;
    bit            busy, acc, own_d, silent;
    int            age;
    logic [AW-1:0] t_addr;
    logic          t_we;
    logic [DW-1:0] t_wdata;
    logic [3:0]    t_wstrb;
    bit            ev_i, ev_d, e_err;
    logic [DW-1:0] e_data;
    logic [DW-1:0] m_irdata, m_drdata;
    bit            i_taken, d_taken;
    int            n_to, n_guard, n_fast;

    task automatic model_reset();
        streak   = 0;
        busy     = 0;
        acc      = 0;
        ev_i     = 0;
        ev_d     = 0;
        m_irdata = '0;
        m_drdata = '0;
        i_taken  = 0;
        d_taken  = 0;
        i_req    = 0;
        d_req    = 0;
        mem_gnt    = 0;
        mem_rvalid = 0;
    endtask

    task automatic drive();
        if (!i_req || i_taken) begin
            i_req  = ($urandom_range(0, 99) < 60);
            i_addr = $urandom;
        end
        if (!d_req || d_taken) begin
            d_req   = ($urandom_range(0, 99) < 70);
            d_we    = $urandom_range(0, 1);
            d_addr  = $urandom;
            d_wdata = $urandom;
            d_wstrb = 4'($urandom);
        end
        mem_rdata = $urandom;
        if (busy && !acc) begin
            mem_gnt    = $urandom_range(0, 1);
            mem_rvalid = mem_gnt && !silent && ($urandom_range(0, 2) == 0);
        end else if (busy) begin
            mem_gnt    = $urandom_range(0, 1);
            mem_rvalid = !silent && ($urandom_range(0, 2) == 0);
        end else begin
            mem_gnt    = $urandom_range(0, 1);
            mem_rvalid = ($urandom_range(0, 3) == 0);
        end
    endtask

    task automatic step();
        bit exp_i, exp_d, done;
        @(negedge clk);
        drive();
        #1;
        chk("i_rvalid", i_rvalid, ev_i);
        chk("d_rvalid", d_rvalid, ev_d);
        if (ev_i) begin
            chk("i_err", i_err, e_err);
            m_irdata = e_data;
        end
        if (ev_d) begin
            chk("d_err", d_err, e_err);
            m_drdata = e_data;
        end
        chk("i_rdata", i_rdata, m_irdata);
        chk("d_rdata", d_rdata, m_drdata);
        ev_i = 0;
        ev_d = 0;
        if (!busy) begin
            exp_d = d_req && !(i_req && streak == MAXB);
            exp_i = !exp_d && i_req;
            if (d_req && i_req && streak == MAXB) n_guard++;
            chk("i_gnt", i_gnt, exp_i);
            chk("d_gnt", d_gnt, exp_d);
            chk("mem_req_idle", mem_req, 0);
            if (exp_d || exp_i) begin
                busy    = 1;
                acc     = 0;
                age     = 0;
                own_d   = exp_d;
                silent  = ($urandom_range(0, 5) == 0);
                t_addr  = exp_d ? d_addr : i_addr;
                t_we    = exp_d && d_we;
                t_wdata = d_wdata;
                t_wstrb = exp_d ? d_wstrb : 4'hf;
            end
            if (exp_d) streak = i_req ? ((streak < MAXB) ? streak + 1 : MAXB) : 0;
            else if (exp_i) streak = 0;
            i_taken = exp_i;
            d_taken = exp_d;
        end else begin
            chk("gnt_busy", {i_gnt, d_gnt}, 0);
            chk("mem_req", mem_req, !acc);
            if (!acc) begin
                chk("mem_addr", mem_addr, t_addr);
                chk("mem_we", mem_we, t_we);
                chk("mem_wstrb", mem_wstrb, t_wstrb);
                if (own_d && t_we) chk("mem_wdata", mem_wdata, t_wdata);
            end
            done = acc ? mem_rvalid : (mem_gnt && mem_rvalid);
            if (done && !acc) n_fast++;
            if (done || age == TO - 1) begin
                ev_i   = !own_d;
                ev_d   = own_d;
                e_err  = !done;
                e_data = done ? mem_rdata : '0;
                busy   = 0;
                if (!done) n_to++;
            end else begin
                acc = acc | mem_gnt;
                age++;
            end
            i_taken = 0;
            d_taken = 0;
        end
    endtask

    initial begin
        n_to    = 0;
        n_guard = 0;
        n_fast  = 0;
        i_addr  = '0;
        d_we    = 0;
        d_addr  = '0;
        d_wdata = '0;
        d_wstrb = '0;
        mem_rdata = '0;
        model_reset();
        rst   = 1;
        i_req = 1;
        d_req = 1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_gnt", {i_gnt, d_gnt}, 0);
        chk("rst_outs", |{i_rvalid, i_rdata, i_err, d_rvalid, d_rdata,
                          d_err, mem_req, mem_we, mem_addr, mem_wdata,
                          mem_wstrb}, 0);
        @(negedge clk);
        model_reset();
        rst = 0;

        for (int n = 0; n < 1500; n++) step();

        // Reset while the memory owes a response
        begin
            int w;
            w = 0;
            while (!(busy && acc) && w < 200) begin
                step();
                w++;
            end
            chk("rst_wait", busy && acc, 1);
        end
        @(negedge clk);
        rst   = 1;
        i_req = 1;
        #1;
        chk("rst2_gnt", {i_gnt, d_gnt}, 0);
        chk("rst2_outs", |{i_rvalid, i_rdata, i_err, d_rvalid, d_rdata,
                           d_err, mem_req, mem_we, mem_addr, mem_wdata,
                           mem_wstrb}, 0);
        mem_rvalid = 1;
        repeat (2) @(negedge clk);
        model_reset();
        rst = 0;

        for (int n = 0; n < 1500; n++) step();

        chk("saw_timeout", n_to > 0, 1);
        chk("saw_guard", n_guard > 0, 1);
        chk("saw_fast", n_fast > 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
